// File: rtl/memlibc_bist_clk_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : memlibc_bist_clk_sched                                     |
// | Description : Round-robin clock/grant scheduler for memory BIST          |
// |               controllers. Only one controller at a time gets its clock  |
// |               enabled. The BIST grant follows after a fixed settle time. |
// |               The clock stays on for a short drain window after the      |
// |               grant drops.                                               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk       scheduler clock, all state updates on the rising edge        |
// |   rst_n     synchronous active-low reset                                 |
// |   sched_en  permits new sessions; does not disturb a running session     |
// |   req       per-controller session request (level)                       |
// |   done      per-controller session complete (level)                      |
// |   clk_en    one-hot-or-zero clock enable to each controller (registered) |
// |   grant     one-hot-or-zero BIST run permission (registered)             |
// |   busy      high whenever the scheduler is not idle (registered)         |
// +--------------------------------------------------------------------------+
module memlibc_bist_clk_sched #(
  parameter int N_REQ      = 4,
  parameter int SETTLE_CYC = 2,
  parameter int GAP_CYC    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sched_en,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] clk_en,
  output logic [N_REQ-1:0] grant,
  output logic             busy
);

  // Index width, plus one extra bit so that ptr + offset cannot overflow
  // before the modulo-N_REQ correction is applied.
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SUM_W = IDX_W + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  // The counters are reloaded with N-1 because the load cycle itself counts
  // as the first cycle of the phase.
  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYC - 1);
  localparam logic [3:0]       GAP_LOAD    = 4'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_REQ - 1);
  localparam logic [SUM_W-1:0] N_SUM       = SUM_W'(N_REQ);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]       state_q,  state_d;
  logic [IDX_W-1:0] cur_q,    cur_d;
  logic [IDX_W-1:0] ptr_q,    ptr_d;
  logic [3:0]       cnt_q,    cnt_d;
  logic [N_REQ-1:0] clk_en_q, clk_en_d;
  logic [N_REQ-1:0] grant_q,  grant_d;
  logic             busy_q,   busy_d;

  // --------------------------------------------------------------------------
  // Round-robin pick: first asserted request at or after ptr, wrapping.
  // --------------------------------------------------------------------------
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [SUM_W-1:0] scan_pos;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    scan_pos   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_pos = {1'b0, ptr_q} + SUM_W'(i);
      // Explicit wrap so non-power-of-two N_REQ never indexes past N_REQ-1.
      if (scan_pos >= N_SUM) begin
        scan_pos = scan_pos - N_SUM;
      end
      if (!pick_found && req[scan_pos[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan_pos[IDX_W-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Session sequencing
  // --------------------------------------------------------------------------
  // Only the current index's req/done are looked at once a session has
  // started; all other requesters are invisible until the next IDLE.
  logic cur_req;
  logic cur_done;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    cur_req  = req[cur_q];
    cur_done = done[cur_q];

    case (state_q)
      ST_IDLE: begin
        // sched_en only gates the start of a session.
        if (sched_en && pick_found) begin
          state_d = ST_SETTLE;
          cur_d   = pick_idx;
          cnt_d   = SETTLE_LOAD;
        end
      end

      ST_SETTLE: begin
        // done is deliberately ignored here: the controller has not been
        // granted yet, so a done level is stale from a previous session.
        if (!cur_req) begin
          state_d = ST_DRAIN;
          cnt_d   = GAP_LOAD;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RUN: begin
        if (cur_done || !cur_req) begin
          state_d = ST_DRAIN;
          cnt_d   = GAP_LOAD;
        end
      end

      ST_DRAIN: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          ptr_d   = (cur_q == LAST_IDX) ? '0 : cur_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode from the next state so the registered outputs line up with
  // the state they describe (no input-to-output combinational path).
  // --------------------------------------------------------------------------
  logic [N_REQ-1:0] cur_onehot;

  always_comb begin
    cur_onehot        = '0;
    cur_onehot[cur_d] = 1'b1;
    clk_en_d          = (state_d != ST_IDLE) ? cur_onehot : '0;
    grant_d           = (state_d == ST_RUN)  ? cur_onehot : '0;
    busy_d            = (state_d != ST_IDLE);
  end

  // --------------------------------------------------------------------------
  // Registers. Reset drops clock and grant on the same edge, no drain.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= 4'd0;
      clk_en_q <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
    end
  end

  assign clk_en = clk_en_q;
  assign grant  = grant_q;
  assign busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_memlibc_bist_clk_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_memlibc_bist_clk_sched                                  |
// | Description : Self-checking bench for memlibc_bist_clk_sched. Two DUTs   |
// |               (N_REQ=4 defaults, and N_REQ=3 with longer settle/gap).    |
// |               A session-level reference model predicts every output.     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_memlibc_bist_clk_sched;

  localparam int A_N = 4, A_SETTLE = 2, A_GAP = 1;
  localparam int B_N = 3, B_SETTLE = 3, B_GAP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n_a, se_a, busy_a;
  logic [A_N-1:0]   req_a, done_a, clk_en_a, grant_a;
  logic             rst_n_b, se_b, busy_b;
  logic [B_N-1:0]   req_b, done_b, clk_en_b, grant_b;

  memlibc_bist_clk_sched #(.N_REQ(A_N), .SETTLE_CYC(A_SETTLE), .GAP_CYC(A_GAP)) u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .sched_en(se_a), .req(req_a), .done(done_a),
    .clk_en(clk_en_a), .grant(grant_a), .busy(busy_a)
  );

  memlibc_bist_clk_sched #(.N_REQ(B_N), .SETTLE_CYC(B_SETTLE), .GAP_CYC(B_GAP)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .sched_en(se_b), .req(req_b), .done(done_b),
    .clk_en(clk_en_b), .grant(grant_b), .busy(busy_b)
  );

  int total = 0;
  int bad   = 0;
  logic mon_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: one record per DUT describing the live session.
  //   act   : a session owns the clock
  //   idx   : owning requester
  //   age   : cycles the clock has been on while waiting for grant
  //   grt   : grant is on
  //   gap   : drain cycles still to go (0 = not draining)
  // --------------------------------------------------------------------------
  int m_act[2], m_idx[2], m_age[2], m_grt[2], m_gap[2], m_ptr[2];

  task automatic model_step(input int u, input int n, input int settle, input int gap,
                            input logic rn, input logic se,
                            input logic [15:0] rq, input logic [15:0] dn);
    if (!rn) begin
      m_act[u] = 0; m_idx[u] = 0; m_age[u] = 0;
      m_grt[u] = 0; m_gap[u] = 0; m_ptr[u] = 0;
    end else if (m_act[u] == 0) begin
      if (se && rq != 16'd0) begin
        for (int k = 0; k < n; k++) begin
          if (rq[(m_ptr[u] + k) % n]) begin
            m_idx[u] = (m_ptr[u] + k) % n;
            break;
          end
        end
        m_act[u] = 1; m_age[u] = 0; m_grt[u] = 0; m_gap[u] = 0;
      end
    end else if (m_gap[u] > 0) begin
      m_gap[u] = m_gap[u] - 1;
      if (m_gap[u] == 0) begin
        m_act[u] = 0;
        m_ptr[u] = (m_idx[u] + 1) % n;
      end
    end else if (m_grt[u] == 0) begin
      if (!rq[m_idx[u]]) begin
        m_gap[u] = gap;
      end else begin
        m_age[u] = m_age[u] + 1;
        if (m_age[u] == settle) m_grt[u] = 1;
      end
    end else if (dn[m_idx[u]] || !rq[m_idx[u]]) begin
      m_grt[u] = 0;
      m_gap[u] = gap;
    end
  endtask

  function automatic logic [31:0] exp_ce(input int u);
    return (m_act[u] != 0) ? (32'd1 << m_idx[u]) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_gr(input int u);
    return (m_act[u] != 0 && m_grt[u] != 0 && m_gap[u] == 0) ? (32'd1 << m_idx[u]) : 32'd0;
  endfunction

  always @(posedge clk) begin
    model_step(0, A_N, A_SETTLE, A_GAP, rst_n_a, se_a, 16'(req_a), 16'(done_a));
    model_step(1, B_N, B_SETTLE, B_GAP, rst_n_b, se_b, 16'(req_b), 16'(done_b));
  end

  // Every-cycle comparison against the model, plus the one-hot properties.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("a_clk_en", 32'(clk_en_a), exp_ce(0));
      chk("a_grant",  32'(grant_a),  exp_gr(0));
      chk("a_busy",   32'(busy_a),   32'(m_act[0] != 0));
      chk("a_onehot", 32'($countones(clk_en_a) <= 1 && $countones(grant_a) <= 1), 32'd1);
      chk("a_gr_in_en", 32'(grant_a & ~clk_en_a), 32'd0);
      chk("b_clk_en", 32'(clk_en_b), exp_ce(1));
      chk("b_grant",  32'(grant_b),  exp_gr(1));
      chk("b_busy",   32'(busy_b),   32'(m_act[1] != 0));
      chk("b_onehot", 32'($countones(clk_en_b) <= 1 && $countones(grant_b) <= 1), 32'd1);
      chk("b_gr_in_en", 32'(grant_b & ~clk_en_b), 32'd0);
    end
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  function automatic int idx_of(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] get_gr(input int u);
    return (u == 0) ? 32'(grant_a) : 32'(grant_b);
  endfunction

  function automatic logic [31:0] get_ce(input int u);
    return (u == 0) ? 32'(clk_en_a) : 32'(clk_en_b);
  endfunction

  task automatic set_done(input int u, input logic [31:0] v);
    if (u == 0) done_a = v[A_N-1:0];
    else        done_b = v[B_N-1:0];
  endtask

  task automatic pulse_reset_a();
    rst_n_a = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // All requesters held high, done pulsed as soon as each grant shows.
  // Expected: service order 0,1,..,n-1,0,..; GAP drain cycles; one idle cycle.
  task automatic rr_run(input int u, input int n, input int gap, input int sessions);
    int cur;
    int w;
    for (int s = 0; s < sessions; s++) begin
      cur = s % n;
      w = 0;
      while (get_gr(u) == 0 && w < 40) begin
        @(negedge clk);
        w++;
      end
      chk("rr_timeout", 32'(w < 40), 32'd1);
      chk("rr_order", 32'(idx_of(get_gr(u))), 32'(cur));
      set_done(u, get_gr(u));
      @(negedge clk);
      set_done(u, 32'd0);
      chk("rr_drain_grant", get_gr(u), 32'd0);
      chk("rr_drain_clk_en", get_ce(u), 32'd1 << cur);
      repeat (gap - 1) @(negedge clk);
      chk("rr_drain_last", get_ce(u), 32'd1 << cur);
      @(negedge clk);
      chk("rr_idle_gap", get_ce(u), 32'd0);
      @(negedge clk);
      chk("rr_next_clk_en", get_ce(u), 32'd1 << ((cur + 1) % n));
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int w;
    // Inputs active during reset must be ignored.
    rst_n_a = 1'b0; se_a = 1'b1; req_a = 4'hF; done_a = 4'hF;
    rst_n_b = 1'b0; se_b = 1'b1; req_b = 3'h7; done_b = 3'h0;
    @(posedge clk);
    mon_on = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_clk_en", 32'(clk_en_a), 32'd0);
    chk("rst_grant",  32'(grant_a),  32'd0);
    chk("rst_busy",   32'(busy_a),   32'd0);

    // Single requester 2: exact cycle timing.
    rst_n_a = 1'b1; req_a = 4'b0100; done_a = 4'b0000; se_a = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1)  chk("t29_c1_clk_en", 32'(clk_en_a), 32'b0100);
      if (c == 2)  chk("t29_c2_grant",  32'(grant_a),  32'b0000);
      if (c == 3)  chk("t29_c3_grant",  32'(grant_a),  32'b0100);
      if (c == 10) done_a = 4'b0100;
      if (c == 11) begin
        chk("t29_c11_grant",  32'(grant_a),  32'b0000);
        chk("t29_c11_clk_en", 32'(clk_en_a), 32'b0100);
        done_a = 4'b0000;
        req_a  = 4'b0000;
      end
      if (c == 12) begin
        chk("t29_c12_clk_en", 32'(clk_en_a), 32'b0000);
        chk("t29_c12_busy",   32'(busy_a),   32'd0);
      end
    end

    // Round-robin across all four.
    pulse_reset_a();
    rst_n_a = 1'b1; req_a = 4'hF; done_a = 4'h0; se_a = 1'b1;
    rr_run(0, A_N, A_GAP, 5);
    req_a = 4'h0;

    // Abort in SETTLE: grant never rises, pointer still advances past 1.
    pulse_reset_a();
    rst_n_a = 1'b1; req_a = 4'b0010; done_a = 4'h0;
    @(negedge clk);
    chk("t31_clk_en_rise", 32'(clk_en_a), 32'b0010);
    @(negedge clk);
    req_a = 4'b0000;
    chk("t31_no_grant_c2", 32'(grant_a), 32'd0);
    @(negedge clk);
    chk("t31_drain_clk_en", 32'(clk_en_a), 32'b0010);
    chk("t31_drain_grant",  32'(grant_a),  32'd0);
    @(negedge clk);
    chk("t31_idle_clk_en", 32'(clk_en_a), 32'd0);
    req_a = 4'hF;
    @(negedge clk);
    chk("t31_ptr_is_2", 32'(clk_en_a), 32'b0100);
    req_a = 4'h0;

    // sched_en low blocks new sessions.
    pulse_reset_a();
    rst_n_a = 1'b1; se_a = 1'b0; req_a = 4'b0011;
    repeat (5) begin
      @(negedge clk);
      chk("t32_blocked_clk_en", 32'(clk_en_a), 32'd0);
      chk("t32_blocked_busy",   32'(busy_a),   32'd0);
    end
    se_a = 1'b1;
    @(negedge clk);
    chk("t32_first_idx0", 32'(clk_en_a), 32'b0001);
    req_a = 4'h0;

    // Reset during RUN of index 3, then done held through SETTLE.
    pulse_reset_a();
    rst_n_a = 1'b1; req_a = 4'b1000; se_a = 1'b1;
    w = 0;
    while (grant_a == 4'd0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("t33_timeout", 32'(w < 20), 32'd1);
    chk("t33_run3", 32'(grant_a), 32'b1000);
    rst_n_a = 1'b0;
    @(negedge clk);
    chk("t33_rst_clk_en", 32'(clk_en_a), 32'd0);
    chk("t33_rst_grant",  32'(grant_a),  32'd0);
    chk("t33_rst_busy",   32'(busy_a),   32'd0);
    rst_n_a = 1'b1; done_a = 4'hF;
    @(negedge clk);
    chk("t33_restart", 32'(clk_en_a), 32'b1000);
    repeat (2) @(negedge clk);
    chk("t33_done_ignored_settle", 32'(grant_a), 32'b1000);
    @(negedge clk);
    chk("t33_done_ends_run", 32'(grant_a), 32'd0);
    req_a = 4'h0; done_a = 4'h0;

    // N_REQ=3 wrap check.
    rst_n_b = 1'b0; req_b = 3'b000;
    repeat (2) @(negedge clk);
    rst_n_b = 1'b1; req_b = 3'b111; done_b = 3'b000; se_b = 1'b1;
    rr_run(1, B_N, B_GAP, 4);

    // Randomized traffic on both DUTs, model checked every cycle.
    repeat (1500) begin
      @(negedge clk);
      rst_n_a = ($urandom_range(0, 149) != 0);
      se_a    = ($urandom_range(0, 7) != 0);
      for (int b = 0; b < A_N; b++) if ($urandom_range(0, 5) == 0) req_a[b] = ~req_a[b];
      done_a  = 4'($urandom) & 4'($urandom);
      rst_n_b = ($urandom_range(0, 149) != 0);
      se_b    = ($urandom_range(0, 7) != 0);
      for (int b = 0; b < B_N; b++) if ($urandom_range(0, 5) == 0) req_b[b] = ~req_b[b];
      done_b  = 3'($urandom) & 3'($urandom);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
